// File: rtl/inst_fetch_seq.sv
// Instruction fetch sequencer: walks ROM addresses from START_ADDR to a latched end
// address and hands each registered word to the datapath over a valid/ready handshake.
module inst_fetch_seq #(
    parameter int                ADDR_W     = 3,
    parameter int                DATA_W     = 19,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   end_q;
    logic [DATA_W-1:0]   instr_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic [ADDR_W-1:0]   pc_d;

    // Natural overflow of the adder gives the modulo-2**ADDR_W wrap.
    assign pc_d = pc_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_ADDR;
            end_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Abort outranks both a pending handshake and a start in IDLE.
            if (abort) begin
                state_q <= S_IDLE;
                pc_q    <= START_ADDR;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            end_q   <= end_addr;
                            pc_q    <= START_ADDR;
                            busy_q  <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        instr_q <= rom_dout;
                        valid_q <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (valid_q && instr_ready) begin
                            valid_q <= 1'b0;
                            if (pc_q == end_q) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                pc_q    <= pc_d;
                                state_q <= S_FETCH;
                            end
                        end
                    end
                    S_DONE: begin
                        pc_q    <= START_ADDR;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_addr    = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Scoreboard bench for inst_fetch_seq: two instances (START_ADDR 0 and 6) share one ROM
// image; a run model queues the expected (address, word) stream checked by a monitor.
module tb_inst_fetch_seq;

    localparam int AW = 3;
    localparam int DW = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic          start       [2];
    logic          abort       [2];
    logic          instr_ready [2];
    logic [AW-1:0] end_addr    [2];
    logic [AW-1:0] rom_addr    [2];
    logic [DW-1:0] rom_dout    [2];
    logic [DW-1:0] instr       [2];
    logic          instr_valid [2];
    logic          busy        [2];
    logic          done        [2];
    logic [DW-1:0] rom         [8];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        inst_fetch_seq #(
            .ADDR_W    (AW),
            .DATA_W    (DW),
            .START_ADDR(gi == 0 ? 3'd0 : 3'd6)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start[gi]),
            .abort      (abort[gi]),
            .end_addr   (end_addr[gi]),
            .rom_addr   (rom_addr[gi]),
            .rom_dout   (rom_dout[gi]),
            .instr      (instr[gi]),
            .instr_valid(instr_valid[gi]),
            .instr_ready(instr_ready[gi]),
            .busy       (busy[gi]),
            .done       (done[gi])
        );
        assign rom_dout[gi] = rom[rom_addr[gi]];
    end

    typedef struct {
        int            inst;
        logic [AW-1:0] addr;
        logic [DW-1:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc  [2];
    bit   first_pend [2];
    int   last_hs    [2];
    bit   prev_valid [2];
    bit   prev_done  [2];
    int   done_cnt   [2];
    int   exp_done   [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected stream of one run: addresses from the instance's start point up to e, wrapping.
    task automatic model_run(input int i, input int e);
        exp_t it;
        int   a;
        a = (i == 0) ? 0 : 6;
        for (int n = 0; n < 8; n++) begin
            it.inst = i;
            it.addr = AW'(a);
            it.word = rom[a];
            sb.push_back(it);
            if (a == e) break;
            a = (a + 1) % 8;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                if (instr_valid[i]) begin
                    check("busy_while_valid", 32'(busy[i]), 32'd1);
                    if (!prev_valid[i]) begin
                        if (first_pend[i]) begin
                            check("first_word_latency", cyc, start_cyc[i] + 3);
                            first_pend[i] = 1'b0;
                        end else begin
                            check("next_word_latency", cyc, last_hs[i] + 2);
                        end
                    end
                    if (sb.size() == 0 || sb[0].inst != i) begin
                        check("word_expected", (sb.size() == 0) ? 32'hffff : sb[0].inst, i);
                    end else begin
                        check("instr", 32'(instr[i]), 32'(sb[0].word));
                        check("rom_addr", 32'(rom_addr[i]), 32'(sb[0].addr));
                        if (instr_ready[i]) begin
                            $display("txn inst%0d addr=%0d instr=%05h cycle=%0d",
                                     i, rom_addr[i], instr[i], cyc);
                            last_hs[i] = cyc;
                            void'(sb.pop_front());
                        end
                    end
                end
                if (done[i]) begin
                    done_cnt[i]++;
                    check("words_left_at_done", sb.size(), 0);
                    check("busy_during_done", 32'(busy[i]), 32'd1);
                end
                if (prev_done[i]) check("busy_after_done", 32'(busy[i]), 32'd0);
            end
            prev_valid[i] = instr_valid[i];
            prev_done[i]  = done[i];
        end
    end

    // One complete program run; optional stall at a given address and a start pulse while busy.
    task automatic run(input int i, input int e, input bit rnd, input int stall_addr, input bit restart);
        int k;
        int stall_left;
        bit stalled;
        stall_left = 0;
        stalled    = 1'b0;
        @(posedge clk); #1;
        instr_ready[i] = rnd ? 1'($urandom % 2) : 1'b1;
        end_addr[i]    = AW'(e);
        start[i]       = 1'b1;
        start_cyc[i]   = cyc;
        first_pend[i]  = 1'b1;
        model_run(i, e);
        exp_done[i]++;
        @(posedge clk); #1;
        start[i]    = 1'b0;
        end_addr[i] = AW'($urandom);
        k = 0;
        while (done_cnt[i] < exp_done[i] && k < 300) begin
            start[i] = restart && (k == 0);
            if (!stalled && stall_addr >= 0 && instr_valid[i] && rom_addr[i] == AW'(stall_addr)) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                instr_ready[i] = 1'b0;
                stall_left--;
            end else begin
                instr_ready[i] = rnd ? 1'($urandom % 2) : 1'b1;
            end
            @(posedge clk); #1;
            k++;
        end
        start[i] = 1'b0;
        check("run_completed", done_cnt[i], exp_done[i]);
        @(posedge clk); #1;
        check("idle_after_run", 32'(busy[i]), 32'd0);
    endtask

    // Start a run to address 3 and park on address 2 with ready low.
    task automatic park_at_addr2(input int i);
        int k;
        @(posedge clk); #1;
        instr_ready[i] = 1'b1;
        end_addr[i]    = 3'd3;
        start[i]       = 1'b1;
        start_cyc[i]   = cyc;
        first_pend[i]  = 1'b1;
        model_run(i, 3);
        @(posedge clk); #1;
        start[i] = 1'b0;
        k = 0;
        while (!(instr_valid[i] && rom_addr[i] == 3'd2) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        instr_ready[i] = 1'b0;
        check("parked_at_addr2", {31'(rom_addr[i]), instr_valid[i]}, {31'd2, 1'b1});
    endtask

    initial begin
        int d0;
        rom[0] = 19'h7f000; rom[1] = 19'h70001; rom[2] = 19'h04040; rom[3] = 19'h7f000;
        for (int a = 4; a < 8; a++) rom[a] = '0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; abort[i] = 1'b0; instr_ready[i] = 1'b0; end_addr[i] = '0;
            first_pend[i] = 1'b0; last_hs[i] = 0; done_cnt[i] = 0; exp_done[i] = 0;
            start_cyc[i] = 0; prev_valid[i] = 1'b0; prev_done[i] = 1'b0;
        end
        reset = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_valid", 32'(instr_valid[i]), 32'd0);
            check("reset_busy", 32'(busy[i]), 32'd0);
            check("reset_done", 32'(done[i]), 32'd0);
            check("reset_instr", 32'(instr[i]), 32'd0);
        end
        check("reset_rom_addr0", 32'(rom_addr[0]), 32'd0);
        check("reset_rom_addr1", 32'(rom_addr[1]), 32'd6);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;

        run(0, 3, 1'b0, -1, 1'b0);   // full run
        run(0, 3, 1'b0, 1, 1'b0);    // stall on 70001
        run(1, 1, 1'b0, -1, 1'b0);   // wrap 6,7,0,1
        run(0, 0, 1'b0, -1, 1'b1);   // single word, start while busy

        // Abort while 04040 is held: no done, outputs back to idle.
        park_at_addr2(0);
        d0 = done_cnt[0];
        @(posedge clk); #1 abort[0] = 1'b1;
        @(posedge clk); #1 abort[0] = 1'b0;
        sb.delete();
        check("abort_valid", 32'(instr_valid[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_rom_addr", 32'(rom_addr[0]), 32'd0);
        repeat (5) @(posedge clk);
        #1 check("abort_no_done", done_cnt[0], d0);

        // Abort and start together in IDLE: nothing starts.
        end_addr[0] = 3'd2; start[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0; abort[0] = 1'b0;
        check("abort_beats_start", 32'(busy[0]), 32'd0);

        // Asynchronous reset mid-run.
        park_at_addr2(0);
        #2 reset = 1'b1;
        #1;
        sb.delete();
        check("arst_valid", 32'(instr_valid[0]), 32'd0);
        check("arst_busy", 32'(busy[0]), 32'd0);
        check("arst_done", 32'(done[0]), 32'd0);
        check("arst_instr", 32'(instr[0]), 32'd0);
        check("arst_rom_addr", 32'(rom_addr[0]), 32'd0);
        @(negedge clk); #1 reset = 1'b0;
        run(0, 0, 1'b0, -1, 1'b0);

        for (int n = 0; n < 10; n++) begin
            run(int'($urandom % 2), int'($urandom % 8), 1'b1, -1, 1'b0);
        end

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
